// File: rtl/mem_bus_arbiter.sv
// Arbitrates the unified memory port between icache and dcache, tracks which
// requester owns each outstanding load tag, and steers tagged returns back.
module mem_bus_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      icache2arb_command,
  input  logic [XLEN-1:0] icache2arb_addr,
  input  logic [1:0]      dcache2arb_command,
  input  logic [XLEN-1:0] dcache2arb_addr,
  input  logic [63:0]     dcache2arb_data,
  output logic [3:0]      arb2icache_response,
  output logic [3:0]      arb2dcache_response,
  output logic [63:0]     arb2icache_data,
  output logic [3:0]      arb2icache_tag,
  output logic [63:0]     arb2dcache_data,
  output logic [3:0]      arb2dcache_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [4:0]      outstanding_cnt,
  output logic            arb_error
);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0]       starve_cnt;
  logic [NUM_TAGS-1:0] tag_valid;
  logic [NUM_TAGS-1:0] tag_owner_dc;  // 1 = dcache owns the tag, 0 = icache

  logic ic_req, ic_illegal, dc_req;
  logic grant_ic, grant_dc;
  logic alloc, same_tag, overwrite;
  logic ret_hit, ret_orphan;
  logic cnt_inc, cnt_dec;

  // Request decode and grant.
  always_comb begin
    ic_req     = (icache2arb_command == BUS_LOAD);
    ic_illegal = (icache2arb_command == BUS_STORE);
    dc_req     = (dcache2arb_command == BUS_LOAD) || (dcache2arb_command == BUS_STORE);
    grant_ic   = ic_req && (!dc_req || (starve_cnt == STARVE_MAX));
    grant_dc   = dc_req && !grant_ic;
  end

  // Table bookkeeping for this cycle's accept and return.
  always_comb begin
    ret_hit    = (mem2proc_tag != 4'd0) && tag_valid[mem2proc_tag];
    ret_orphan = (mem2proc_tag != 4'd0) && !tag_valid[mem2proc_tag];
    alloc      = (grant_ic || (grant_dc && (dcache2arb_command == BUS_LOAD)))
                 && (mem2proc_response != 4'd0);
    // A tag freed by this cycle's return may be legally reissued in the same cycle.
    same_tag   = ret_hit && (mem2proc_tag == mem2proc_response);
    overwrite  = alloc && tag_valid[mem2proc_response] && !same_tag;
    cnt_inc    = alloc && (!tag_valid[mem2proc_response] || same_tag);
    cnt_dec    = ret_hit;
  end

  // Memory-side drive, accept-tag forwarding and return steering.
  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    arb2icache_response = 4'd0;
    arb2dcache_response = 4'd0;
    arb2icache_tag      = 4'd0;
    arb2dcache_tag      = 4'd0;
    arb2icache_data     = mem2proc_data;
    arb2dcache_data     = mem2proc_data;
    if (!reset) begin
      if (grant_ic) begin
        proc2mem_command    = BUS_LOAD;
        proc2mem_addr       = icache2arb_addr;
        arb2icache_response = mem2proc_response;
      end else if (grant_dc) begin
        proc2mem_command    = dcache2arb_command;
        proc2mem_addr       = dcache2arb_addr;
        proc2mem_data       = dcache2arb_data;
        arb2dcache_response = mem2proc_response;
      end
      if (ret_hit) begin
        if (tag_owner_dc[mem2proc_tag]) arb2dcache_tag = mem2proc_tag;
        else                            arb2icache_tag = mem2proc_tag;
      end
    end
  end

  // NOTE: the owner table is plain flops, not RAM, so it is cleared on reset;
  // stale valid bits would otherwise misroute returns issued before reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid       <= '0;
      tag_owner_dc    <= '0;
      starve_cnt      <= '0;
      outstanding_cnt <= '0;
      arb_error       <= 1'b0;
    end else begin
      if (ret_hit) tag_valid[mem2proc_tag] <= 1'b0;
      // NOTE: the allocation is written after the clear so that, with
      // non-blocking semantics, a same-tag reissue wins over the return.
      if (alloc) begin
        tag_valid[mem2proc_response]    <= 1'b1;
        tag_owner_dc[mem2proc_response] <= grant_dc;
      end

      if (ic_req && dc_req && !grant_ic) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end

      case ({cnt_inc, cnt_dec})
        2'b10:   outstanding_cnt <= outstanding_cnt + 5'd1;
        2'b01:   outstanding_cnt <= outstanding_cnt - 5'd1;
        default: outstanding_cnt <= outstanding_cnt;
      endcase

      if (ret_orphan || overwrite || ic_illegal) arb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grant, starvation, tag routing, errors, reset.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache2arb_command;
  logic [31:0] icache2arb_addr;
  logic [1:0]  dcache2arb_command;
  logic [31:0] dcache2arb_addr;
  logic [63:0] dcache2arb_data;
  logic [3:0]  arb2icache_response, arb2dcache_response;
  logic [63:0] arb2icache_data, arb2dcache_data;
  logic [3:0]  arb2icache_tag, arb2dcache_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [4:0]  outstanding_cnt;
  logic        arb_error;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.XLEN(32), .NUM_TAGS(16), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .icache2arb_command(icache2arb_command), .icache2arb_addr(icache2arb_addr),
    .dcache2arb_command(dcache2arb_command), .dcache2arb_addr(dcache2arb_addr),
    .dcache2arb_data(dcache2arb_data),
    .arb2icache_response(arb2icache_response), .arb2dcache_response(arb2dcache_response),
    .arb2icache_data(arb2icache_data), .arb2icache_tag(arb2icache_tag),
    .arb2dcache_data(arb2dcache_data), .arb2dcache_tag(arb2dcache_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .outstanding_cnt(outstanding_cnt), .arb_error(arb_error)
  );

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    icache2arb_command = 2'd0; icache2arb_addr = '0;
    dcache2arb_command = 2'd0; dcache2arb_addr = '0; dcache2arb_data = '0;
    mem2proc_response  = 4'd0; mem2proc_data   = '0; mem2proc_tag    = 4'd0;
    #1;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    icache2arb_command = 2'd1; icache2arb_addr = 32'h10;
    dcache2arb_command = 2'd1; dcache2arb_addr = 32'h20;
    mem2proc_response = 4'd3; mem2proc_tag = 4'd3; mem2proc_data = 64'h55;
    #1;
    total++; if (proc2mem_command !== 2'd0) $display("FAIL rst_cmd: got %0d want 0", proc2mem_command); else passed++;
    total++; if (proc2mem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", proc2mem_addr); else passed++;
    total++; if (arb2icache_response !== 4'd0 || arb2dcache_response !== 4'd0)
      $display("FAIL rst_resp: got i=%0d d=%0d want 0/0", arb2icache_response, arb2dcache_response); else passed++;
    total++; if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0)
      $display("FAIL rst_tags: got i=%0d d=%0d want 0/0", arb2icache_tag, arb2dcache_tag); else passed++;
    tick(); tick();
    total++; if (outstanding_cnt !== 5'd0) $display("FAIL rst_cnt: got %0d want 0", outstanding_cnt); else passed++;
    total++; if (arb_error !== 1'b0) $display("FAIL rst_err: got %0b want 0", arb_error); else passed++;
    reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_icache_only();
    icache2arb_command = 2'd1; icache2arb_addr = 32'h100; mem2proc_response = 4'd3;
    #1;
    total++; if (proc2mem_command !== 2'd1) $display("FAIL ic_cmd: got %0d want 1", proc2mem_command); else passed++;
    total++; if (proc2mem_addr !== 32'h100) $display("FAIL ic_addr: got %h want 100", proc2mem_addr); else passed++;
    total++; if (proc2mem_data !== 64'h0) $display("FAIL ic_data: got %h want 0", proc2mem_data); else passed++;
    total++; if (arb2icache_response !== 4'd3) $display("FAIL ic_resp: got %0d want 3", arb2icache_response); else passed++;
    total++; if (arb2dcache_response !== 4'd0) $display("FAIL ic_dresp: got %0d want 0", arb2dcache_response); else passed++;
    tick();
    idle();
    total++; if (outstanding_cnt !== 5'd1) $display("FAIL ic_cnt1: got %0d want 1", outstanding_cnt); else passed++;
    tick();
    mem2proc_tag = 4'd3; mem2proc_data = 64'h1122_3344_5566_7788;
    #1;
    total++; if (arb2icache_tag !== 4'd3) $display("FAIL ic_rtag: got %0d want 3", arb2icache_tag); else passed++;
    total++; if (arb2dcache_tag !== 4'd0) $display("FAIL ic_rtag_d: got %0d want 0", arb2dcache_tag); else passed++;
    total++; if (arb2icache_data !== 64'h1122_3344_5566_7788) $display("FAIL ic_rdata: got %h want 1122334455667788", arb2icache_data); else passed++;
    tick();
    idle();
    total++; if (outstanding_cnt !== 5'd0) $display("FAIL ic_cnt0: got %0d want 0", outstanding_cnt); else passed++;
    total++; if (arb_error !== 1'b0) $display("FAIL ic_err: got %0b want 0", arb_error); else passed++;
  endtask

  task automatic test_starvation();
    logic [3:0] exp_i, exp_d;
    for (int i = 0; i < 6; i++) begin
      icache2arb_command = 2'd1; icache2arb_addr = 32'h200;
      dcache2arb_command = 2'd1; dcache2arb_addr = 32'h300;
      mem2proc_response = 4'(i + 1);
      #1;
      total++;
      if (proc2mem_addr !== ((i == 4) ? 32'h200 : 32'h300))
        $display("FAIL starve_addr cyc%0d: got %h want %h", i, proc2mem_addr, (i == 4) ? 32'h200 : 32'h300);
      else passed++;
      exp_i = (i == 4) ? 4'(i + 1) : 4'd0;
      exp_d = (i == 4) ? 4'd0 : 4'(i + 1);
      total++;
      if (arb2icache_response !== exp_i || arb2dcache_response !== exp_d)
        $display("FAIL starve_resp cyc%0d: got i=%0d d=%0d want i=%0d d=%0d", i,
                 arb2icache_response, arb2dcache_response, exp_i, exp_d);
      else passed++;
      tick();
    end
    idle();
    total++; if (outstanding_cnt !== 5'd6) $display("FAIL starve_cnt6: got %0d want 6", outstanding_cnt); else passed++;
    for (int t = 1; t <= 6; t++) begin
      mem2proc_tag = 4'(t);
      #1;
      exp_i = (t == 5) ? 4'(t) : 4'd0;
      exp_d = (t == 5) ? 4'd0 : 4'(t);
      total++;
      if (arb2icache_tag !== exp_i || arb2dcache_tag !== exp_d)
        $display("FAIL starve_route tag%0d: got i=%0d d=%0d want i=%0d d=%0d", t,
                 arb2icache_tag, arb2dcache_tag, exp_i, exp_d);
      else passed++;
      tick();
    end
    idle();
    total++; if (outstanding_cnt !== 5'd0) $display("FAIL starve_cnt0: got %0d want 0", outstanding_cnt); else passed++;
  endtask

  task automatic test_store();
    dcache2arb_command = 2'd2; dcache2arb_addr = 32'h400;
    dcache2arb_data = 64'hDEADBEEF_CAFEF00D; mem2proc_response = 4'd5;
    #1;
    total++; if (proc2mem_command !== 2'd2) $display("FAIL st_cmd: got %0d want 2", proc2mem_command); else passed++;
    total++; if (proc2mem_data !== 64'hDEADBEEF_CAFEF00D) $display("FAIL st_data: got %h want deadbeefcafef00d", proc2mem_data); else passed++;
    total++; if (arb2dcache_response !== 4'd5) $display("FAIL st_resp: got %0d want 5", arb2dcache_response); else passed++;
    tick();
    idle();
    total++; if (outstanding_cnt !== 5'd0) $display("FAIL st_cnt: got %0d want 0", outstanding_cnt); else passed++;
    mem2proc_tag = 4'd5;
    #1;
    total++; if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0)
      $display("FAIL st_orphan_tags: got i=%0d d=%0d want 0/0", arb2icache_tag, arb2dcache_tag); else passed++;
    tick();
    idle();
    total++; if (arb_error !== 1'b1) $display("FAIL st_err: got %0b want 1", arb_error); else passed++;
    pulse_reset();
  endtask

  task automatic test_same_cycle_tag();
    icache2arb_command = 2'd1; icache2arb_addr = 32'h700; mem2proc_response = 4'd7;
    tick();
    idle();
    dcache2arb_command = 2'd1; dcache2arb_addr = 32'h500;
    mem2proc_response = 4'd7; mem2proc_tag = 4'd7;
    #1;
    total++; if (arb2icache_tag !== 4'd7 || arb2dcache_tag !== 4'd0)
      $display("FAIL same_route: got i=%0d d=%0d want 7/0", arb2icache_tag, arb2dcache_tag); else passed++;
    total++; if (arb2dcache_response !== 4'd7) $display("FAIL same_resp: got %0d want 7", arb2dcache_response); else passed++;
    tick();
    idle();
    total++; if (outstanding_cnt !== 5'd1) $display("FAIL same_cnt: got %0d want 1", outstanding_cnt); else passed++;
    total++; if (arb_error !== 1'b0) $display("FAIL same_err: got %0b want 0", arb_error); else passed++;
    mem2proc_tag = 4'd7;
    #1;
    total++; if (arb2dcache_tag !== 4'd7 || arb2icache_tag !== 4'd0)
      $display("FAIL same_newowner: got i=%0d d=%0d want 0/7", arb2icache_tag, arb2dcache_tag); else passed++;
    tick();
    idle();
    total++; if (outstanding_cnt !== 5'd0) $display("FAIL same_cnt0: got %0d want 0", outstanding_cnt); else passed++;
  endtask

  task automatic test_busy();
    for (int i = 0; i < 5; i++) begin
      icache2arb_command = 2'd1; icache2arb_addr = 32'h600;
      dcache2arb_command = 2'd1; dcache2arb_addr = 32'h680;
      mem2proc_response = 4'd0;
      #1;
      total++;
      if (proc2mem_addr !== ((i == 4) ? 32'h600 : 32'h680))
        $display("FAIL busy_addr cyc%0d: got %h want %h", i, proc2mem_addr, (i == 4) ? 32'h600 : 32'h680);
      else passed++;
      total++;
      if (arb2icache_response !== 4'd0 || arb2dcache_response !== 4'd0)
        $display("FAIL busy_resp cyc%0d: got i=%0d d=%0d want 0/0", i, arb2icache_response, arb2dcache_response);
      else passed++;
      tick();
    end
    idle();
    total++; if (outstanding_cnt !== 5'd0) $display("FAIL busy_cnt: got %0d want 0", outstanding_cnt); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int t = 1; t <= 3; t++) begin
      dcache2arb_command = 2'd1; dcache2arb_addr = 32'h800 + 32'(t); mem2proc_response = 4'(t);
      tick();
    end
    idle();
    total++; if (outstanding_cnt !== 5'd3) $display("FAIL mid_cnt3: got %0d want 3", outstanding_cnt); else passed++;
    reset = 1'b1;
    dcache2arb_command = 2'd1; dcache2arb_addr = 32'h900; mem2proc_response = 4'd4;
    #1;
    total++; if (proc2mem_command !== 2'd0) $display("FAIL mid_cmd: got %0d want 0", proc2mem_command); else passed++;
    total++; if (arb2dcache_response !== 4'd0) $display("FAIL mid_resp: got %0d want 0", arb2dcache_response); else passed++;
    tick();
    reset = 1'b0;
    idle();
    total++; if (outstanding_cnt !== 5'd0) $display("FAIL mid_cnt0: got %0d want 0", outstanding_cnt); else passed++;
    total++; if (arb_error !== 1'b0) $display("FAIL mid_err0: got %0b want 0", arb_error); else passed++;
    mem2proc_tag = 4'd2;
    #1;
    total++; if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0)
      $display("FAIL mid_tags: got i=%0d d=%0d want 0/0", arb2icache_tag, arb2dcache_tag); else passed++;
    tick();
    idle();
    total++; if (arb_error !== 1'b1) $display("FAIL mid_err1: got %0b want 1", arb_error); else passed++;
  endtask

  task automatic test_icache_store();
    pulse_reset();
    icache2arb_command = 2'd2; icache2arb_addr = 32'hA00; mem2proc_response = 4'd9;
    #1;
    total++; if (proc2mem_command !== 2'd0) $display("FAIL icst_cmd: got %0d want 0", proc2mem_command); else passed++;
    total++; if (arb2icache_response !== 4'd0) $display("FAIL icst_resp: got %0d want 0", arb2icache_response); else passed++;
    tick();
    idle();
    total++; if (arb_error !== 1'b1) $display("FAIL icst_err: got %0b want 1", arb_error); else passed++;
    total++; if (outstanding_cnt !== 5'd0) $display("FAIL icst_cnt: got %0d want 0", outstanding_cnt); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    test_reset();
    test_icache_only();
    test_starvation();
    test_store();
    test_same_cycle_tag();
    test_busy();
    test_reset_mid();
    test_icache_store();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
